// File: rtl/point_affine_param.sv
// Projective (Jacobian or homogeneous) to affine converter over GF(p), with one time-shared
// bit-serial Montgomery multiplier and Fermat inversion Z^(p-2).
module point_affine_param #(
  parameter int LEN = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           ready,
  input  logic           mode,
  input  logic [LEN-1:0] p,
  input  logic [LEN-1:0] r2_mod_p,
  input  logic [LEN-1:0] x,
  input  logic [LEN-1:0] y,
  input  logic [LEN-1:0] z,
  output logic [LEN-1:0] rx,
  output logic [LEN-1:0] ry,
  output logic           inf,
  output logic           done
);

  // state | meaning
  // IDLE  | waiting for start
  // ZCHK  | z==0 test, infinity shortcut
  // TOM   | zm = z*R, acc = R mod p
  // EXP   | acc = z^(p-2) in Montgomery form
  // MUL   | rx/ry from acc (and its square in Jacobian mode)
  // FIN   | done pulse
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ZCHK = 3'd1;
  localparam logic [2:0] S_TOM  = 3'd2;
  localparam logic [2:0] S_EXP  = 3'd3;
  localparam logic [2:0] S_MUL  = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  localparam int CW = $clog2(LEN + 1);
  localparam int BW = $clog2(LEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(LEN);
  localparam logic [BW-1:0]  BIT_TOP  = BW'(LEN - 1);
  localparam logic [LEN-1:0] ONE      = {{(LEN-1){1'b0}}, 1'b1};

  logic [2:0]     state_q, state_d;
  logic           mode_q, mode_d, inf_q, inf_d, sq_q, sq_d;
  logic [LEN-1:0] p_q, p_d, r2_q, r2_d, x_q, x_d, y_q, y_d, z_q, z_d, e_q, e_d;
  logic [LEN-1:0] zm_q, zm_d, acc_q, acc_d, t_q, t_d, rxw_q, rxw_d, rx_q, rx_d, ry_q, ry_d;
  logic [LEN+1:0] mac_q, mac_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [1:0]     step_q, step_d;

  logic [LEN-1:0] op_a, op_b, mm_res;
  logic [LEN+1:0] sum1, sum2, mac_step;
  logic           a_bit, e_bit, mm_last, mul_last;

  always_comb begin
    op_a = acc_q;
    op_b = acc_q;
    case (state_q)
      S_TOM: begin
        op_a = step_q[0] ? ONE : z_q;
        op_b = r2_q;
      end
      S_EXP: op_b = sq_q ? zm_q : acc_q;
      S_MUL: begin
        if (mode_q) begin
          op_a = step_q[0] ? y_q : x_q;
        end else begin
          case (step_q)
            2'd1:    begin op_a = x_q; op_b = t_q;   end
            2'd2:    begin op_a = t_q; op_b = acc_q; end
            2'd3:    begin op_a = y_q; op_b = t_q;   end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // One add/shift iteration per cycle; accumulator stays below 2p, so the final step is a single subtract.
  always_comb begin
    a_bit    = |(op_a & (ONE << cnt_q));
    e_bit    = |(e_q & (ONE << bit_q));
    sum1     = mac_q + (a_bit ? {2'b00, op_b} : '0);
    sum2     = sum1[0] ? (sum1 + {2'b00, p_q}) : sum1;
    mac_step = sum2 >> 1;
    mm_res   = LEN'((mac_q >= {2'b00, p_q}) ? (mac_q - {2'b00, p_q}) : mac_q);
    mm_last  = (cnt_q == CNT_LAST);
    mul_last = mode_q ? (step_q == 2'd1) : (step_q == 2'd3);
  end

  always_comb begin
    state_d = state_q; mode_d = mode_q; inf_d = inf_q; sq_d = sq_q;
    p_d = p_q; r2_d = r2_q; x_d = x_q; y_d = y_q; z_d = z_q; e_d = e_q;
    zm_d = zm_q; acc_d = acc_q; t_d = t_q; rxw_d = rxw_q; rx_d = rx_q; ry_d = ry_q;
    mac_d = mac_q; cnt_d = cnt_q; bit_d = bit_q; step_d = step_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_ZCHK;
        mode_d  = mode;
        p_d     = p;
        r2_d    = r2_mod_p;
        x_d     = x;
        y_d     = y;
        z_d     = z;
        e_d     = p - LEN'(2);
        inf_d   = 1'b0;
      end
      S_ZCHK: begin
        cnt_d  = '0;
        mac_d  = '0;
        step_d = 2'd0;
        sq_d   = 1'b0;
        bit_d  = BIT_TOP;
        if (z_q == '0) begin
          state_d = S_FIN;
          inf_d   = 1'b1;
          rx_d    = '0;
          ry_d    = '0;
        end else begin
          state_d = S_TOM;
        end
      end
      S_TOM, S_EXP, S_MUL: begin
        if (!mm_last) begin
          mac_d = mac_step;
          cnt_d = cnt_q + CW'(1);
        end else begin
          mac_d = '0;
          cnt_d = '0;
          if (state_q == S_TOM) begin
            if (!step_q[0]) begin
              zm_d   = mm_res;
              step_d = 2'd1;
            end else begin
              acc_d   = mm_res;
              step_d  = 2'd0;
              state_d = S_EXP;
            end
          end else if (state_q == S_EXP) begin
            acc_d = mm_res;
            if (!sq_q && e_bit) begin
              sq_d = 1'b1;
            end else begin
              sq_d = 1'b0;
              if (bit_q == '0) state_d = S_MUL;
              else             bit_d = bit_q - BW'(1);
            end
          end else if (mul_last) begin
            rx_d    = rxw_q;
            ry_d    = mm_res;
            state_d = S_FIN;
          end else begin
            step_d = step_q + 2'd1;
            // Homogeneous step 0 and Jacobian step 1 produce x; the other Jacobian steps build the t powers.
            if (mode_q || step_q == 2'd1) rxw_d = mm_res;
            else                          t_d   = mm_res;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE; mode_q <= 1'b0; inf_q <= 1'b0; sq_q <= 1'b0;
      p_q <= '0; r2_q <= '0; x_q <= '0; y_q <= '0; z_q <= '0; e_q <= '0;
      zm_q <= '0; acc_q <= '0; t_q <= '0; rxw_q <= '0; rx_q <= '0; ry_q <= '0;
      mac_q <= '0; cnt_q <= '0; bit_q <= '0; step_q <= '0;
    end else begin
      state_q <= state_d; mode_q <= mode_d; inf_q <= inf_d; sq_q <= sq_d;
      p_q <= p_d; r2_q <= r2_d; x_q <= x_d; y_q <= y_d; z_q <= z_d; e_q <= e_d;
      zm_q <= zm_d; acc_q <= acc_d; t_q <= t_d; rxw_q <= rxw_d; rx_q <= rx_d; ry_q <= ry_d;
      mac_q <= mac_d; cnt_q <= cnt_d; bit_q <= bit_d; step_q <= step_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = (state_q == S_FIN);
  assign rx    = rx_q;
  assign ry    = ry_q;
  assign inf   = inf_q;

endmodule

// File: tb/tb_point_affine_param.sv
// Scoreboard bench for point_affine_param at LEN=16, p=0xFFF1: directed vectors with hand-computed results.
module tb_point_affine_param;
  localparam int LEN = 16;
  localparam int POPC = 15;  // popcount(0xFFEF)

  logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
  logic [LEN-1:0] p_in = 16'hFFF1, r2_in = 16'h00E1;
  logic [LEN-1:0] x = '0, y = '0, z = '0;
  logic [LEN-1:0] rx, ry;
  logic           ready, inf, done;

  point_affine_param #(.LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .mode(mode),
    .p(p_in), .r2_mod_p(r2_in), .x(x), .y(y), .z(z),
    .rx(rx), .ry(ry), .inf(inf), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LEN-1:0] rx;
    logic [LEN-1:0] ry;
    logic           inf;
    int             lat;
    int             acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   errors = 0, checks = 0;
  int   last_done = -100;
  int   ac;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endfunction

  function automatic int lat_of(logic m, logic [LEN-1:0] zz);
    if (zz == '0) return 2;
    return 2 + (LEN + 1) * (2 + LEN + POPC + (m ? 2 : 4));
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      last_done = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("rx", rx, e.rx);
        chk("ry", ry, e.ry);
        chk("inf", inf, e.inf);
        chk("latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic drive(logic m, logic [LEN-1:0] xx, logic [LEN-1:0] yy, logic [LEN-1:0] zz);
    mode = m; x = xx; y = yy; z = zz;
  endtask

  task automatic accept(output int a);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready never rose");
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
  endtask

  task automatic issue(logic m, logic [LEN-1:0] xx, logic [LEN-1:0] yy, logic [LEN-1:0] zz,
                       logic [LEN-1:0] erx, logic [LEN-1:0] ery, logic einf, bit hold);
    int a;
    exp_t n;
    drive(m, xx, yy, zz);
    accept(a);
    n.rx = erx; n.ry = ery; n.inf = einf; n.lat = lat_of(m, zz); n.acc = a;
    sb.push_back(n);
    if (!hold) start = 1'b0;
    chk("ready_drop", ready, 0);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 3000; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_inf", inf, 0);
    chk("rst_rx", rx, 0);
    chk("rst_ry", ry, 0);
    rst_n = 1'b1;

    issue(0, 16'd8, 16'd24, 16'd2, 16'd2, 16'd3, 0, 0);
    issue(1, 16'd30, 16'd45, 16'd15, 16'd2, 16'd3, 0, 0);
    issue(0, 16'h1234, 16'hABCD, 16'd1, 16'h1234, 16'hABCD, 0, 0);
    issue(1, 16'hFFF0, 16'h0000, 16'd1, 16'hFFF0, 16'h0000, 0, 0);
    issue(0, 16'd18, 16'd81, 16'd3, 16'd2, 16'd3, 0, 0);
    issue(0, 16'd7, 16'd7, 16'hFFF0, 16'd7, 16'hFFEA, 0, 0);
    issue(1, 16'd5, 16'd0, 16'hFFF0, 16'hFFEC, 16'd0, 0, 0);

    issue(0, 16'h55, 16'h66, 16'd0, 16'd0, 16'd0, 1, 0);
    wait_empty();
    @(negedge clk);
    chk("inf_hold", inf, 1);
    issue(1, 16'd10, 16'd20, 16'd5, 16'd2, 16'd4, 0, 0);
    chk("inf_clear", inf, 0);
    wait_empty();

    // start held high while the inputs wander; only the latched vector counts
    issue(0, 16'd18, 16'd81, 16'd3, 16'd2, 16'd3, 0, 1);
    repeat (40) @(negedge clk);
    drive(1, 16'd1, 16'd2, 16'd7);
    repeat (300) @(negedge clk);
    drive(1, 16'd5, 16'd0, 16'hFFF0);
    accept(ac);
    e.rx = 16'hFFEC; e.ry = 16'd0; e.inf = 1'b0; e.lat = lat_of(1, 16'hFFF0); e.acc = ac;
    sb.push_back(e);
    start = 1'b0;
    chk("reaccept_cycle", ac, last_done + 2);
    wait_empty();

    drive(0, 16'd7, 16'd7, 16'hFFF0);
    accept(ac);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_rx", rx, 0);
    chk("abort_ry", ry, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1, 16'd30, 16'd45, 16'd15, 16'd2, 16'd3, 0, 0);
    wait_empty();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
